// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and helpers for the multiplexed display controller
package display_pkg;
  localparam int         SEG_W       = 7;
  localparam int         PHASES      = 16;
  localparam logic [3:0] DEAD_PHASE  = 4'd0;
  localparam logic       EN_INACTIVE = 1'b1;

  typedef logic [3:0] phase_t;

  // A digit is driven only outside dead time and while the phase is within its on-time.
  function automatic logic phase_lit(input phase_t phase, input logic [3:0] bright);
    return (phase != DEAD_PHASE) && (phase <= bright);
  endfunction
endpackage

// File: rtl/mux_display_ctrl_tick_gen.sv
// rtl/mux_display_ctrl_tick_gen.sv - free-running prescaler, one tick per 2^PRESCALER_BITS clocks
module tick_gen #(
  parameter int PRESCALER_BITS = 12
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [PRESCALER_BITS-1:0] cnt_q;
  logic [PRESCALER_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + PRESCALER_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = &cnt_q;
endmodule

// File: rtl/mux_display_ctrl.sv
// rtl/mux_display_ctrl.sv - time-multiplexed 7-segment scan controller with PWM brightness
// Optional per-digit blink is compiled in with DISPLAY_BLINK_EN.
module mux_display_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS         = 4,
  parameter int PRESCALER_BITS   = 12,
  parameter int BLINK_FRAME_BITS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEG_W*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [3:0]                brightness,
`ifdef DISPLAY_BLINK_EN
  input  logic [N_DIGITS-1:0]       blink_mask,
`endif
  output logic [N_DIGITS-1:0]       en_disp,
  output logic [7:0]                digit_out,
  output logic                      frame_start
);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic             tick;
  logic             slot_end;
  logic             frame_wrap;
  logic             hide_d;

  phase_t           phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEG_W-1:0] seg_snap_q, seg_snap_d;
  logic             dp_snap_q, dp_snap_d;
  logic [3:0]       bright_q, bright_d;
  logic [N_DIGITS-1:0] en_disp_q, en_disp_d;
  logic             frame_start_q, frame_start_d;

  tick_gen #(.PRESCALER_BITS(PRESCALER_BITS)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Snapshots load only on the edge into phase 0, so segment data never changes while a digit is lit.
  always_comb begin
    phase_d       = phase_q;
    idx_d         = idx_q;
    seg_snap_d    = seg_snap_q;
    dp_snap_d     = dp_snap_q;
    bright_d      = bright_q;
    slot_end      = tick && (phase_q == phase_t'(PHASES - 1));
    frame_wrap    = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
    frame_start_d = frame_wrap;
    if (tick) phase_d = phase_q + phase_t'(1);
    if (slot_end) begin
      idx_d      = frame_wrap ? '0 : idx_q + IDX_W'(1);
      seg_snap_d = digits_in[idx_d*SEG_W +: SEG_W];
      dp_snap_d  = dp_in[idx_d];
      bright_d   = brightness;
    end
  end

`ifdef DISPLAY_BLINK_EN
  logic [BLINK_FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                        blink_hidden_q, blink_hidden_d;
  logic                        blink_snap_q, blink_snap_d;

  always_comb begin
    frame_cnt_d    = frame_cnt_q;
    blink_hidden_d = blink_hidden_q;
    blink_snap_d   = blink_snap_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + BLINK_FRAME_BITS'(1);
      if (&frame_cnt_q) blink_hidden_d = ~blink_hidden_q;
    end
    if (slot_end) blink_snap_d = blink_mask[idx_d];
    hide_d = blink_hidden_d && blink_snap_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
      blink_snap_q   <= 1'b0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      blink_hidden_q <= blink_hidden_d;
      blink_snap_q   <= blink_snap_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (BLINK_FRAME_BITS > 0);
  assign hide_d     = 1'b0;
`endif

  // Enables are computed from next-state phase/index so they line up with phase_q without extra latency.
  always_comb begin
    en_disp_d = {N_DIGITS{EN_INACTIVE}};
    if (phase_lit(phase_d, bright_d) && !hide_d) en_disp_d[idx_d] = ~EN_INACTIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= DEAD_PHASE;
      idx_q         <= '0;
      seg_snap_q    <= '0;
      dp_snap_q     <= 1'b0;
      bright_q      <= '0;
      en_disp_q     <= {N_DIGITS{EN_INACTIVE}};
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      seg_snap_q    <= seg_snap_d;
      dp_snap_q     <= dp_snap_d;
      bright_q      <= bright_d;
      en_disp_q     <= en_disp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign en_disp     = en_disp_q;
  assign digit_out   = {dp_snap_q, seg_snap_q};
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_mux_display_ctrl.sv
// tb/tb_mux_display_ctrl.sv - self-checking bench for mux_display_ctrl (N_DIGITS=4, PRESCALER_BITS=2)
module tb_mux_display_ctrl;
  localparam int N  = 4;
  localparam int NV = 10;
  localparam logic [27:0] D0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [27:0]  digits_in = D0;
  logic [N-1:0] dp_in = 4'b0001;
  logic [3:0]   brightness = 4'd15;
`ifdef DISPLAY_BLINK_EN
  logic [N-1:0] blink_mask = '0;
`endif
  logic [N-1:0] en_disp;
  logic [7:0]   digit_out;
  logic         frame_start;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [27:0] digits;
    logic [3:0]  dp;
    logic [3:0]  bright;
    int          slot;
    logic [7:0]  exp_dig;
    int          exp_lit;
  } vec_t;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  mux_display_ctrl #(.N_DIGITS(N), .PRESCALER_BITS(2), .BLINK_FRAME_BITS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .brightness  (brightness),
`ifdef DISPLAY_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .en_disp     (en_disp),
    .digit_out   (digit_out),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the caller at the sample point of cycle 0 (prescaler 0, phase 0, slot 0).
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int lit, stray, dbad, np, multi;
    logic [7:0] dseen;
    logic [3:0] on_pat;
    int pulses [3];

    vecs[0] = '{D0, 4'b0001, 4'd15, 0, 8'h00, 0};
    vecs[1] = '{D0, 4'b0001, 4'd15, 1, 8'h06, 60};
    vecs[2] = '{D0, 4'b0001, 4'd15, 4, 8'hBF, 60};
    vecs[3] = '{D0, 4'b0001, 4'd4,  1, 8'h06, 16};
    vecs[4] = '{D0, 4'b0001, 4'd4,  2, 8'h5B, 16};
    vecs[5] = '{D0, 4'b0001, 4'd0,  3, 8'h4F, 0};
    vecs[6] = '{D0, 4'b0001, 4'd1,  3, 8'h4F, 4};
    vecs[7] = '{D0, 4'b1010, 4'd8,  3, 8'hCF, 32};
    vecs[8] = '{D0, 4'b1010, 4'd15, 5, 8'h86, 60};
    vecs[9] = '{D0, 4'b0001, 4'd2,  7, 8'h4F, 8};

    @(negedge clk);
    check("reset en_disp", int'(en_disp), 4'hF);
    check("reset digit_out", int'(digit_out), 8'h00);
    check("reset frame_start", int'(frame_start), 0);

    for (int v = 0; v < NV; v++) begin
      digits_in  = vecs[v].digits;
      dp_in      = vecs[v].dp;
      brightness = vecs[v].bright;
      do_reset();
      repeat (vecs[v].slot * 64) @(negedge clk);
      on_pat = ~(4'b0001 << (vecs[v].slot % N));
      lit = 0; stray = 0; dbad = 0; dseen = digit_out;
      for (int c = 0; c < 64; c++) begin
        if (digit_out != vecs[v].exp_dig && dbad == 0) begin
          dbad++;
          dseen = digit_out;
        end
        if (en_disp == on_pat) lit++;
        else if (en_disp != 4'hF) stray++;
        if (c < 4 && en_disp != 4'hF) stray++;
        @(negedge clk);
      end
      check($sformatf("vec%0d digit_out", v), int'(dseen), int'(vecs[v].exp_dig));
      check($sformatf("vec%0d lit cycles", v), lit, vecs[v].exp_lit);
      check($sformatf("vec%0d stray enables", v), stray, 0);
    end

    // Mid-slot input change is held off until the next slot.
    digits_in = D0; dp_in = 4'b0001; brightness = 4'd15;
    do_reset();
    repeat (160) @(negedge clk);
    check("midslot before", int'(digit_out), 8'h5B);
    digits_in = {7'h4F, 7'h7D, 7'h06, 7'h3F};
    dbad = 0;
    for (int c = 0; c < 32; c++) begin
      if (digit_out != 8'h5B) dbad++;
      @(negedge clk);
    end
    check("midslot held", dbad, 0);
    check("midslot next slot", int'(digit_out), 8'h4F);
    repeat (384 - 192) @(negedge clk);
    check("midslot next frame", int'(digit_out), 8'h7D);

    // Frame pulses over three frames.
    digits_in = D0;
    do_reset();
    np = 0; multi = 0;
    for (int c = 0; c < 800; c++) begin
      if (frame_start) begin
        if (np < 3) pulses[np] = c;
        np++;
      end
      if ($countones(~en_disp) > 1) multi++;
      @(negedge clk);
    end
    check("frame_start count", np, 3);
    check("frame_start first", pulses[0], 256);
    check("frame_start spacing1", pulses[1] - pulses[0], 256);
    check("frame_start spacing2", pulses[2] - pulses[1], 256);
    check("multi low enables", multi, 0);

    // Asynchronous reset at phase 10 of slot 3.
    do_reset();
    repeat (233) @(negedge clk);
    check("pre-rst en_disp", int'(en_disp), 4'b0111);
    check("pre-rst digit_out", int'(digit_out), 8'h4F);
    #2 rst = 1'b1;
    #1;
    check("async rst en_disp", int'(en_disp), 4'hF);
    check("async rst digit_out", int'(digit_out), 8'h00);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post-rst slot0 digit", int'(digit_out), 8'h00);
    check("post-rst slot0 en", int'(en_disp), 4'hF);
    repeat (69) @(negedge clk);
    check("post-rst slot1 digit", int'(digit_out), 8'h06);
    check("post-rst slot1 en", int'(en_disp), 4'b1101);

`ifdef DISPLAY_BLINK_EN
    blink_mask = 4'b0100;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      int lit1, lit2;
      lit1 = 0; lit2 = 0;
      for (int c = 0; c < 256; c++) begin
        if (!en_disp[1]) lit1++;
        if (!en_disp[2]) lit2++;
        @(negedge clk);
      end
      check($sformatf("blink frame%0d digit2", f), lit2, (f == 2 || f == 3) ? 0 : 60);
      check($sformatf("blink frame%0d digit1", f), lit1, 60);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_display_ctrl.md
MUX_DISPLAY_CTRL -- requirements
Module: mux_display_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter PRESCALER_BITS, default 12, prescaler width; one tick every 2^PRESCALER_BITS clk cycles.
REQ-003 Parameter BLINK_FRAME_BITS, default 6, blink half-period of 2^BLINK_FRAME_BITS frames (used only with DISPLAY_BLINK_EN).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 digits_in  in  7*N_DIGITS  segment patterns; digit k at [7k+6:7k].
REQ-007 dp_in  in  N_DIGITS  decimal points; bit k belongs to digit k.
REQ-008 brightness  in  4  global on-time, 0 = dark, 15 = maximum.
REQ-009 blink_mask  in  N_DIGITS  per-digit blink enable (present only with DISPLAY_BLINK_EN).
REQ-010 en_disp  out  N_DIGITS  digit enables, active-low, registered.
REQ-011 digit_out  out  8  {dp, seg[6:0]} of the active digit, registered.
REQ-012 frame_start  out  1  one-cycle pulse at the start of each scan frame.

Function
REQ-013 Prescaler: PRESCALER_BITS free-running counter; tick=1 in the cycle where the counter is all ones.
REQ-014 Slot: 16 ticks per digit, 4-bit phase counter advancing on tick, 15 wraps to 0.
REQ-015 Scan index: advances on the tick where phase wraps 15->0; N_DIGITS-1 wraps to 0; non-power-of-two N_DIGITS skips no slot and never reaches an illegal index.
REQ-016 Phase 0 = dead time: en_disp all ones.
REQ-017 Phases 1..15: en_disp bit idx low iff phase <= brightness_snap; all other bits high always.
REQ-018 Snapshot: on the edge entering phase 0, capture digits_in slice idx_next, dp_in[idx_next], brightness into registers; mid-slot input changes are ignored until the next slot.
REQ-019 digit_out = {dp_snap, seg_snap}, valid from phase 0 onward, so segments change only while all enables are inactive.
REQ-020 Outputs are registered from next-state values: no added latency relative to phase/idx.
REQ-021 frame_start high exactly one cycle, the cycle after the edge where idx wraps N_DIGITS-1 -> 0; never asserted directly out of reset.
REQ-022 At most one enable bit is low in any cycle.
REQ-023 brightness = 0: en_disp all ones for the whole slot; brightness = 15: digit on for phases 1..15.

Reset
REQ-024 rst asserted: prescaler 0, phase 0, idx 0, snapshots 0, en_disp all ones, digit_out 8'h00, frame_start 0, blink state 0 (visible), frame counter 0.
REQ-025 Slot 0 after reset uses the reset snapshot (dark); first live data appears in slot 1.
REQ-026 rst mid-slot: outputs reach reset values asynchronously in the same cycle; scanning restarts from slot 0 phase 0.

Configuration
REQ-027 Macro DISPLAY_BLINK_EN defined: blink_mask port exists; frame counter of BLINK_FRAME_BITS toggles blink state on overflow; while blink state = hidden, digits with blink_mask bit set (captured at phase 0) keep enables high.
REQ-028 Macro undefined: no blink_mask port, no frame counter, no blink state; behaviour identical to defined with blink_mask = 0.

Structure
REQ-029 Shared package display_pkg: SEG_W = 7, PHASES = 16, DEAD_PHASE = 0, EN_INACTIVE = 1'b1.
REQ-030 One sub-module tick_gen (parameter PRESCALER_BITS; clk, rst in; tick out) provides the prescaler.

Verification (N_DIGITS=4, PRESCALER_BITS=2: tick every 4 clk, slot 64 clk, frame 256 clk)
REQ-031 Reset then digits_in = {7'h4F,7'h5B,7'h06,7'h3F}, dp_in = 4'b0001, brightness = 15 -> slot 0 dark; slot 1 digit_out 8'h06, en_disp 4'b1101 for 60 clk after 4 dead clk; the slot-0 repeat at frame 2 shows 8'hBF.
REQ-032 brightness = 4 -> each enable low exactly 16 of 64 clk per slot; brightness = 0 -> en_disp stays 4'b1111.
REQ-033 Change digits_in at phase 8 of slot 2 -> digit_out unchanged until next phase 0; change visible in slot 2 of the following frame.
REQ-034 Run 3 frames -> frame_start pulses exactly 3 times, 256 clk apart, each 1 clk wide; en_disp never has two low bits.
REQ-035 Assert rst at phase 10 of slot 3 -> en_disp = 4'b1111, digit_out = 8'h00 immediately; after release, idx restarts at 0.
REQ-036 DISPLAY_BLINK_EN, BLINK_FRAME_BITS=1, blink_mask = 4'b0100 -> digit 2 lit 2 frames, dark 2 frames, repeating; other digits unaffected.
